// File: rtl/port_pkg.sv
// Shared opcode/state encodings and default port addresses for the port
// read-modify-write controller.
package port_pkg;

    typedef enum logic [2:0] {
        OP_MOV  = 3'b000,
        OP_ANL  = 3'b001,
        OP_ORL  = 3'b010,
        OP_XRL  = 3'b011,
        OP_SETB = 3'b100,
        OP_CLR  = 3'b101,
        OP_CPL  = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CALC,
        ST_WRITE,
        ST_ERR
    } state_t;

    localparam logic [7:0] P0_DEFAULT = 8'h80;
    localparam logic [7:0] P1_DEFAULT = 8'h90;
    localparam logic [7:0] P2_DEFAULT = 8'hA0;
    localparam logic [7:0] P3_DEFAULT = 8'hB0;

    function automatic logic is_port(
        input logic [7:0] a,
        input logic [7:0] p0,
        input logic [7:0] p1,
        input logic [7:0] p2,
        input logic [7:0] p3
    );
        return (a == p0) || (a == p1) || (a == p2) || (a == p3);
    endfunction

endpackage

// File: rtl/port_rmw_alu.sv
// Combinational modify step of a port read-modify-write: byte logic ops and
// single-bit complement (returned in bit 0).
module port_rmw_alu
    import port_pkg::*;
(
    input  logic [2:0] op,
    input  logic [7:0] rd_data,
    input  logic [7:0] operand,
    input  logic [2:0] bit_idx,
    output logic [7:0] result
);

    always_comb begin
        result = '0;
        case (op_t'(op))
            OP_ANL:  result = rd_data & operand;
            OP_ORL:  result = rd_data | operand;
            OP_XRL:  result = rd_data ^ operand;
            OP_CPL:  result = {7'b0, ~rd_data[bit_idx]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/port_rmw_ctrl.sv
// Port SFR read-modify-write sequencer: accepts one byte/bit operation per
// request, reads the port latch when needed and issues a single bus write.
module port_rmw_ctrl
    import port_pkg::*;
#(
    parameter logic [7:0] P0_ADDR = P0_DEFAULT,
    parameter logic [7:0] P1_ADDR = P1_DEFAULT,
    parameter logic [7:0] P2_ADDR = P2_DEFAULT,
    parameter logic [7:0] P3_ADDR = P3_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] op,
    input  logic [7:0] addr,
    input  logic [7:0] operand,
    output logic       ack,
    output logic       done,
    output logic       err,
    output logic       ready,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] port_addr,
    output logic [7:0] port_data_in,
    output logic       port_write_en,
    output logic       port_write_bit_en,
    output logic       port_bit_in
);

    state_t     state, state_nx;
    op_t        op_q;
    logic [7:0] addr_q, operand_q, result_q, alu_result;
    logic [7:0] base_in, base_q;
    logic       req_valid, req_rmw;

    assign base_in   = op[2] ? (addr & 8'hF8) : addr;
    assign base_q    = op_q[2] ? (addr_q & 8'hF8) : addr_q;
    assign req_valid = (op_t'(op) != OP_RSVD) &&
                       is_port(base_in, P0_ADDR, P1_ADDR, P2_ADDR, P3_ADDR);
    assign req_rmw   = (op_t'(op) == OP_ANL) || (op_t'(op) == OP_ORL) ||
                       (op_t'(op) == OP_XRL) || (op_t'(op) == OP_CPL);

    port_rmw_alu u_alu (
        .op      (op_q),
        .rd_data (rd_data),
        .operand (operand_q),
        .bit_idx (addr_q[2:0]),
        .result  (alu_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_MOV;
            addr_q    <= '0;
            operand_q <= '0;
            result_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req) begin
                op_q      <= op_t'(op);
                addr_q    <= addr;
                operand_q <= operand;
            end
            if (state == ST_CALC) begin
                result_q <= alu_result;
            end
        end
    end

    always_comb begin
        state_nx          = state;
        ack               = 1'b0;
        done              = 1'b0;
        err               = 1'b0;
        ready             = 1'b0;
        rd_addr           = '0;
        port_addr         = '0;
        port_data_in      = '0;
        port_write_en     = 1'b0;
        port_write_bit_en = 1'b0;
        port_bit_in       = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    ack = 1'b1;
                    if (!req_valid)   state_nx = ST_ERR;
                    else if (req_rmw) state_nx = ST_READ;
                    else              state_nx = ST_WRITE;
                end
            end
            ST_READ: begin
                rd_addr  = base_q;
                state_nx = ST_CALC;
            end
            ST_CALC: begin
                rd_addr  = base_q;
                state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                port_write_en = 1'b1;
                done          = 1'b1;
                port_addr     = addr_q;
                // MOV never passes through CALC, so its data comes straight from the operand
                if (op_q[2]) begin
                    port_write_bit_en = 1'b1;
                    port_bit_in       = (op_q == OP_SETB) ? 1'b1 :
                                        (op_q == OP_CPL)  ? result_q[0] : 1'b0;
                end else begin
                    port_data_in = (op_q == OP_MOV) ? operand_q : result_q;
                end
                state_nx = ST_IDLE;
            end
            ST_ERR: begin
                err      = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_port_rmw_ctrl.sv
// Directed and randomized checks of port_rmw_ctrl against a port-latch
// reference model held in this bench.
module tb_port_rmw_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [2:0] op = '0;
    logic [7:0] addr = '0;
    logic [7:0] operand = '0;
    logic       ack, done, err, ready;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic [7:0] port_addr, port_data_in;
    logic       port_write_en, port_write_bit_en, port_bit_in;

    logic [7:0] latch [256];
    int vectors = 0;
    int miscompares = 0;

    port_rmw_ctrl #(
        .P0_ADDR(8'h80),
        .P1_ADDR(8'h90),
        .P2_ADDR(8'hA0),
        .P3_ADDR(8'hB0)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req               (req),
        .op                (op),
        .addr              (addr),
        .operand           (operand),
        .ack               (ack),
        .done              (done),
        .err               (err),
        .ready             (ready),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .port_addr         (port_addr),
        .port_data_in      (port_data_in),
        .port_write_en     (port_write_en),
        .port_write_bit_en (port_write_bit_en),
        .port_bit_in       (port_bit_in)
    );

    always #5 clock = ~clock;

    // Port latch memory: value appears one cycle after its address is presented.
    always @(posedge clock) rd_data <= latch[rd_addr];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_port_addr(input logic [7:0] a);
        return a == 8'h80 || a == 8'h90 || a == 8'hA0 || a == 8'hB0;
    endfunction

    // One complete operation with req dropped after ack; checks every cycle until IDLE.
    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] d);
        logic [7:0]  base, cur, exp_data;
        logic        isbit, valid, rmw, exp_bit;
        int unsigned lat;
        isbit = o[2];
        base  = isbit ? (a & 8'hF8) : a;
        valid = (o != 3'd7) && is_port_addr(base);
        rmw   = (o == 3'd1) || (o == 3'd2) || (o == 3'd3) || (o == 3'd6);
        lat   = (valid && rmw) ? 3 : 1;
        cur   = latch[base];
        case (o)
            3'd0:    exp_data = d;
            3'd1:    exp_data = cur & d;
            3'd2:    exp_data = cur | d;
            3'd3:    exp_data = cur ^ d;
            default: exp_data = '0;
        endcase
        exp_bit = (o == 3'd4) ? 1'b1 : (o == 3'd6) ? ~cur[a[2:0]] : 1'b0;

        @(negedge clock);
        check("ready_before", {7'b0, ready}, 8'd1);
        req = 1'b1; op = o; addr = a; operand = d;
        #1;
        check("ack", {7'b0, ack}, 8'd1);
        @(negedge clock);
        req = 1'b0; op = 3'($urandom); addr = 8'($urandom); operand = 8'($urandom);
        for (int unsigned k = 1; k <= lat + 1; k++) begin
            if (k > 1) @(negedge clock);
            #1;
            check("ready", {7'b0, ready}, {7'b0, k == lat + 1});
            if (!valid) begin
                check("err", {7'b0, err}, {7'b0, k == 1});
                check("we_on_err", {7'b0, port_write_en}, 8'd0);
                check("done_on_err", {7'b0, done}, 8'd0);
            end else begin
                check("err_valid", {7'b0, err}, 8'd0);
                check("we", {7'b0, port_write_en}, {7'b0, k == lat});
                check("done", {7'b0, done}, {7'b0, k == lat});
                check("rd_addr", rd_addr, (rmw && k < lat) ? base : 8'h00);
                if (k == lat) begin
                    check("port_addr", port_addr, a);
                    check("bit_en", {7'b0, port_write_bit_en}, {7'b0, isbit});
                    if (isbit) check("bit_in", {7'b0, port_bit_in}, {7'b0, exp_bit});
                    else       check("data_in", port_data_in, exp_data);
                end else begin
                    check("port_addr_idle", port_addr, 8'h00);
                end
            end
        end
        if (valid) begin
            if (isbit) latch[base][a[2:0]] = exp_bit;
            else       latch[base] = exp_data;
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [7:0]  ra, pbase, xrl_exp;
        int unsigned acks;
        for (int i = 0; i < 256; i++) latch[i] = 8'($urandom);

        // Reset state
        #12;
        check("rst_ready", {7'b0, ready}, 8'd1);
        check("rst_ack", {7'b0, ack}, 8'd0);
        check("rst_we", {7'b0, port_write_en}, 8'd0);
        check("rst_rd_addr", rd_addr, 8'h00);
        check("rst_err", {7'b0, err}, 8'd0);
        @(negedge clock);
        reset = 1'b0;

        // ORL 90 held, then XRL queued behind it; ORL data A0|0F
        latch[8'h90] = 8'hA0;
        xrl_exp = latch[8'hA0] ^ 8'h3C;
        @(negedge clock);
        req = 1'b1; op = 3'd2; addr = 8'h90; operand = 8'h0F;
        #1;
        check("orl_ack", {7'b0, ack}, 8'd1);
        acks = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            op = 3'd3; addr = 8'hA0; operand = 8'h3C;
            #1;
            if (ack) acks++;
            check("orl_we", {7'b0, port_write_en}, {7'b0, k == 3});
            check("orl_done", {7'b0, done}, {7'b0, k == 3});
        end
        check("orl_addr", port_addr, 8'h90);
        check("orl_data", port_data_in, 8'hAF);
        check("busy_acks", 8'(acks), 8'd0);
        @(negedge clock);
        #1;
        check("xrl_ack_after_write", {7'b0, ack}, 8'd1);
        @(negedge clock);
        req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clock);
            #1;
            check("xrl_we", {7'b0, port_write_en}, {7'b0, k == 3});
        end
        check("xrl_data", port_data_in, xrl_exp);
        latch[8'h90] = 8'hAF;
        latch[8'hA0] = xrl_exp;

        // SETB A5, CPL 83 with latch 08, invalid MOV C0, reserved op
        do_op(3'd4, 8'hA5, 8'h00);
        latch[8'h80] = 8'h08;
        do_op(3'd6, 8'h83, 8'h00);
        do_op(3'd0, 8'hC0, 8'h12);
        do_op(3'd7, 8'h80, 8'h00);

        // Reset asserted in CALC aborts the operation
        @(negedge clock);
        req = 1'b1; op = 3'd1; addr = 8'h80; operand = 8'hF0;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_ready", {7'b0, ready}, 8'd1);
        check("abort_rd_addr", rd_addr, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("abort_no_we", {7'b0, port_write_en}, 8'd0);
            check("abort_no_done", {7'b0, done}, 8'd0);
        end
        do_op(3'd0, 8'hB0, 8'h55);

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom);
            pbase = 8'h80 + 8'(16 * $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) ra = 8'($urandom);
            else if (ro[2])                ra = pbase | 8'($urandom_range(0, 7));
            else                           ra = pbase;
            do_op(ro, ra, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/port_rmw_ctrl.md
PORT_RMW_CTRL -- requirements
Module: port_rmw_ctrl

Interface
REQ-001 SHALL have parameter P0_ADDR, default 8'h80, meaning the byte address of port P0 and the base bit address of P0.
REQ-002 SHALL have parameters P1_ADDR, P2_ADDR and P3_ADDR, defaults 8'h90, 8'hA0 and 8'hB0, meaning the byte and base bit addresses of ports P1, P2 and P3.
REQ-003 SHALL have clock  in  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have req  in  1  operation request, held by the requester until ack.
REQ-006 SHALL have op  in  3  opcode: 000 MOV, 001 ANL, 010 ORL, 011 XRL, 100 SETB, 101 CLR, 110 CPL, 111 reserved.
REQ-007 SHALL have addr  in  8  byte address for op[2]=0; bit address (byte base | bit index) for op[2]=1.
REQ-008 SHALL have operand  in  8  byte operand; ignored for bit ops.
REQ-009 SHALL have ack  out  1  one-cycle pulse when a request is accepted.
REQ-010 SHALL have done  out  1  one-cycle pulse in the write cycle of a successful operation.
REQ-011 SHALL have err  out  1  one-cycle pulse for a rejected operation.
REQ-012 SHALL have ready  out  1  high only in IDLE.
REQ-013 SHALL have rd_addr  out  8  byte address of the port latch to read.
REQ-014 SHALL have rd_data  in  8  selected port latch value, valid one cycle after rd_addr is driven.
REQ-015 SHALL have port_addr, port_data_in, port_write_en, port_write_bit_en, port_bit_in  out  8/8/1/1/1  port SFR write bus.

Function
REQ-016 SHALL implement the states IDLE, READ, CALC, WRITE and ERR.
REQ-017 SHALL, in IDLE with req=1, pulse ack, latch op, addr and operand, and transition on the next edge.
REQ-018 SHALL treat a byte op as valid only when addr equals one of P0_ADDR..P3_ADDR.
REQ-019 SHALL treat a bit op as valid only when addr & 8'hF8 equals one of P0_ADDR..P3_ADDR.
REQ-020 SHALL route an invalid address or op=111 from IDLE to ERR, pulse err there, then return to IDLE with no bus write.
REQ-021 SHALL route MOV, SETB and CLR directly from IDLE to WRITE, giving a write 1 cycle after ack.
REQ-022 SHALL route ANL, ORL, XRL and CPL through IDLE -> READ -> CALC -> WRITE, giving a write 3 cycles after ack.
REQ-023 SHALL, in READ, drive rd_addr = byte address (addr & 8'hF8 for bit ops).
REQ-024 SHALL, in CALC, capture rd_data and register the result: ANL rd&operand, ORL rd|operand, XRL rd^operand, CPL ~rd[addr[2:0]].
REQ-025 SHALL, in WRITE for a byte op, assert port_write_en=1 and port_write_bit_en=0, with port_addr = addr and port_data_in = result.
REQ-026 SHALL, in WRITE for a bit op, assert port_write_en=1 and port_write_bit_en=1, with port_addr = bit address and port_bit_in = 1 (SETB), 0 (CLR) or the CALC result (CPL).
REQ-027 SHALL keep port_write_en high for exactly one cycle per operation and pulse done in that same cycle.
REQ-028 SHALL return to IDLE after WRITE, so back-to-back requests are accepted with ack on the cycle after WRITE.
REQ-029 SHALL ignore req outside IDLE and SHALL NOT queue it.
REQ-030 SHALL hold all bus outputs at 0 when not in WRITE, and rd_addr stable from READ through CALC.

Reset
REQ-031 SHALL, while reset=1, asynchronously force state=IDLE, ready=1, and all other outputs and registers to 0.
REQ-032 SHALL, on reset during READ, CALC or WRITE, abort the operation with no further port write and no done pulse.

Structure
REQ-033 SHALL place the opcode constants, the state encoding and the default port addresses in shared package port_pkg.
REQ-034 SHALL place the combinational byte/bit result logic in sub-module port_rmw_alu (inputs op, rd_data, operand, bit index; output result).

Verification
REQ-035 SHALL verify: ORL with addr 8'h90, operand 8'h0F, rd_data 8'hA0 -> ack; write at ack+3 with port_addr 8'h90 and data 8'hAF; done in the same cycle.
REQ-036 SHALL verify: SETB with addr 8'hA5 -> write at ack+1 with write_bit_en=1, port_addr 8'hA5 and bit_in=1; rd_addr never driven.
REQ-037 SHALL verify: CPL with addr 8'h83 and rd_data 8'h08 -> rd_addr 8'h80; write with bit_in=0.
REQ-038 SHALL verify: MOV with addr 8'hC0, and separately op=111 -> err pulse, no port_write_en, ready again 2 cycles after ack.
REQ-039 SHALL verify: an XRL request held across a busy operation -> exactly one ack per operation, and a second ack on the cycle after WRITE.
REQ-040 SHALL verify: reset asserted in CALC -> immediate IDLE, no write, no done; then a MOV of 8'h55 to 8'hB0 completes normally.
